// File: rtl/mem_stage_if.sv
// Byte-wide synchronous RAM port used by mem_stage (master) and the RAM (slave).
// Carries fallback operand widths/opcodes for builds that do not pull in config.v.
`ifndef OpCodeLen
`define OpCodeLen 8
`define RegLen 32
`define RegAddrLen 5
`define AddrLen 32
`define NOP 8'h00
`define ADD 8'h01
`define LB 8'h20
`define LH 8'h21
`define LW 8'h22
`define LBU 8'h23
`define LHU 8'h24
`define SB 8'h28
`define SH 8'h29
`define SW 8'h2A
`endif

interface mem_stage_if;
    logic [`AddrLen-1:0] mem_a;
    logic [7:0]          mem_dout;
    logic                mem_wr;
    logic [7:0]          mem_din;

    modport master (output mem_a, output mem_dout, output mem_wr, input mem_din);
    modport slave  (input mem_a, input mem_dout, input mem_wr, output mem_din);
endinterface

// File: rtl/mem_stage.sv
// MEM stage: byte-serial loads/stores over a 1-cycle RAM, stalls the pipe while busy.
// Optional MEM_MISALIGN_CHECK_EN rejects misaligned H/W accesses with a misalign_o pulse.
`ifndef OpCodeLen
`define OpCodeLen 8
`define RegLen 32
`define RegAddrLen 5
`define AddrLen 32
`define NOP 8'h00
`define ADD 8'h01
`define LB 8'h20
`define LH 8'h21
`define LW 8'h22
`define LBU 8'h23
`define LHU 8'h24
`define SB 8'h28
`define SH 8'h29
`define SW 8'h2A
`endif

module mem_stage #(
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`OpCodeLen-1:0]  aluop_i,
    input  logic [`RegLen-1:0]     rd_data_i,
    input  logic [`RegAddrLen-1:0] rd_addr_i,
    input  logic                   rd_enable_i,
    input  logic [`AddrLen-1:0]    mem_addr_i,
    mem_stage_if.master            mem,
    output logic                   stall_req,
    output logic [`RegLen-1:0]     rd_data_o,
    output logic [`RegAddrLen-1:0] rd_addr_o,
    output logic                   rd_enable_o,
    output logic                   misalign_o
);

    generate
        if (MEM_LAT != 1) begin : g_bad_lat
            $error("mem_stage supports only MEM_LAT = 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [`OpCodeLen-1:0]   op_q, op_d;
    logic [`AddrLen-1:0]     addr_q, addr_d, mema_q, mema_d, cur_addr;
    logic [`RegLen-1:0]      sdata_q, sdata_d;
    logic [31:0]             buf_q, buf_d;
    logic [`RegAddrLen-1:0]  rda_q, rda_d;
    logic                    rde_q, rde_d;
    logic                    misal;

    function automatic logic is_load(input logic [`OpCodeLen-1:0] op);
        return (op == `LB) || (op == `LH) || (op == `LW) || (op == `LBU) || (op == `LHU);
    endfunction

    function automatic logic is_store(input logic [`OpCodeLen-1:0] op);
        return (op == `SB) || (op == `SH) || (op == `SW);
    endfunction

    function automatic logic [1:0] last_idx(input logic [`OpCodeLen-1:0] op);
        if ((op == `LH) || (op == `LHU) || (op == `SH)) return 2'd1;
        if ((op == `LW) || (op == `SW))                 return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [31:0] extend(input logic [`OpCodeLen-1:0] op, input logic [31:0] b);
        if (op == `LB)  return {{24{b[7]}}, b[7:0]};
        if (op == `LBU) return {24'h0, b[7:0]};
        if (op == `LH)  return {{16{b[15]}}, b[15:0]};
        if (op == `LHU) return {16'h0, b[15:0]};
        return b;
    endfunction

`ifdef MEM_MISALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [`OpCodeLen-1:0] op, input logic [`AddrLen-1:0] a);
        if (last_idx(op) == 2'd1) return a[0];
        if (last_idx(op) == 2'd3) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction
`endif

    // Byte address wraps naturally at 2^32.
    assign cur_addr = addr_q + {{(`AddrLen-2){1'b0}}, cnt_q};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        addr_d       = addr_q;
        sdata_d      = sdata_q;
        buf_d        = buf_q;
        rda_d        = rda_q;
        rde_d        = rde_q;
        mema_d       = mema_q;
        mem.mem_a    = mema_q;
        mem.mem_dout = 8'h00;
        mem.mem_wr   = 1'b0;
        stall_req    = 1'b0;
        rd_data_o    = '0;
        rd_addr_o    = '0;
        rd_enable_o  = 1'b0;
        misalign_o   = 1'b0;
        misal        = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        misal        = is_misaligned(aluop_i, mem_addr_i);
`endif

        case (state_q)
            IDLE: begin
                if (!(is_load(aluop_i) || is_store(aluop_i))) begin
                    rd_data_o   = rd_data_i;
                    rd_addr_o   = rd_addr_i;
                    rd_enable_o = rd_enable_i;
                end else if (misal) begin
                    misalign_o = 1'b1;
                end else begin
                    stall_req = 1'b1;
                    op_d      = aluop_i;
                    addr_d    = mem_addr_i;
                    sdata_d   = rd_data_i;
                    rda_d     = rd_addr_i;
                    rde_d     = rd_enable_i;
                    buf_d     = '0;
                    cnt_d     = 2'd0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                mem.mem_a = cur_addr;
                mema_d    = cur_addr;
                if (is_store(op_q)) begin
                    mem.mem_wr   = 1'b1;
                    mem.mem_dout = sdata_q[{cnt_q, 3'b000} +: 8];
                end else if (cnt_q != 2'd0) begin
                    // RAM data arriving now belongs to the previous cycle's address.
                    buf_d[{cnt_q - 2'd1, 3'b000} +: 8] = mem.mem_din;
                end
                if (cnt_q == last_idx(op_q)) begin
                    state_d = is_load(op_q) ? WAIT : DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            WAIT: begin
                stall_req = 1'b1;
                buf_d[{last_idx(op_q), 3'b000} +: 8] = mem.mem_din;
                state_d = DONE;
            end
            DONE: begin
                rd_addr_o = rda_q;
                if (is_load(op_q)) begin
                    rd_data_o   = extend(op_q, buf_q);
                    rd_enable_o = rde_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            mem.mem_wr   = 1'b0;
            mem.mem_dout = 8'h00;
            stall_req    = 1'b0;
            rd_data_o    = '0;
            rd_addr_o    = '0;
            rd_enable_o  = 1'b0;
            misalign_o   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            op_q    <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            buf_q   <= '0;
            rda_q   <= '0;
            rde_q   <= 1'b0;
            mema_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            buf_q   <= buf_d;
            rda_q   <= rda_d;
            rde_q   <= rde_d;
            mema_q  <= mema_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table with a result scoreboard, a behavioural byte RAM and a mid-store reset case.
`ifndef OpCodeLen
`define OpCodeLen 8
`define RegLen 32
`define RegAddrLen 5
`define AddrLen 32
`define NOP 8'h00
`define ADD 8'h01
`define LB 8'h20
`define LH 8'h21
`define LW 8'h22
`define LBU 8'h23
`define LHU 8'h24
`define SB 8'h28
`define SH 8'h29
`define SW 8'h2A
`endif

module tb_mem_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [`OpCodeLen-1:0]  aluop;
    logic [`RegLen-1:0]     rd_data_in;
    logic [`RegAddrLen-1:0] rd_addr_in;
    logic                   rd_en_in;
    logic [`AddrLen-1:0]    addr_in;
    logic                   stall_req;
    logic [`RegLen-1:0]     rd_data_out;
    logic [`RegAddrLen-1:0] rd_addr_out;
    logic                   rd_en_out;
    logic                   misalign;

    mem_stage_if mif();

    mem_stage #(.MEM_LAT(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluop_i     (aluop),
        .rd_data_i   (rd_data_in),
        .rd_addr_i   (rd_addr_in),
        .rd_enable_i (rd_en_in),
        .mem_addr_i  (addr_in),
        .mem         (mif),
        .stall_req   (stall_req),
        .rd_data_o   (rd_data_out),
        .rd_addr_o   (rd_addr_out),
        .rd_enable_o (rd_en_out),
        .misalign_o  (misalign)
    );

    // Behavioural RAM: 1 KiB aliased over the address space, one-cycle read latency.
    logic [7:0]  ram [0:1023] = '{default: 8'h00};
    logic [39:0] wr_log [$];
    always @(posedge clk) begin
        if (mif.mem_wr) begin
            ram[mif.mem_a[9:0]] <= mif.mem_dout;
            wr_log.push_back({mif.mem_a, mif.mem_dout});
        end
        mif.mem_din <= ram[mif.mem_a[9:0]];
    end

    typedef struct {
        logic [`OpCodeLen-1:0]  op;
        logic [31:0]            d;
        logic [`RegAddrLen-1:0] ra;
        logic                   re;
        logic [31:0]            addr;
        logic [31:0]            ed;
        logic [`RegAddrLen-1:0] ea;
        logic                   ee;
        logic                   em;
        int                     lat;
        int                     nwr;
    } vec_t;

    vec_t tbl [$];
    vec_t sb  [$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic [`OpCodeLen-1:0] op, input logic [31:0] d,
                                input logic [`RegAddrLen-1:0] ra, input logic re, input logic [31:0] a,
                                input logic [31:0] ed, input logic [`RegAddrLen-1:0] ea, input logic ee,
                                input logic em, input int lat, input int nwr);
        vec_t v;
        v.op = op; v.d = d; v.ra = ra; v.re = re; v.addr = a;
        v.ed = ed; v.ea = ea; v.ee = ee; v.em = em; v.lat = lat; v.nwr = nwr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        aluop      = v.op;
        rd_data_in = v.d;
        rd_addr_in = v.ra;
        rd_en_in   = v.re;
        addr_in    = v.addr;
    endtask

    // Called just after a rising edge; returns just after the edge that ends the result cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          base;
        vec_t        e;
        logic [39:0] w;
        logic [31:0] t;
        drive(v);
        base = wr_log.size();
        sb.push_back(v);
        lat = 1;
        @(negedge clk);
        while (stall_req === 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk($sformatf("v%0d stall_release", idx), {31'b0, stall_req}, 32'h0);
        chk($sformatf("v%0d latency", idx), lat, e.lat);
        if (!e.em) begin
            chk($sformatf("v%0d rd_data", idx), rd_data_out, e.ed);
            chk($sformatf("v%0d rd_addr", idx), {27'b0, rd_addr_out}, {27'b0, e.ea});
        end
        chk($sformatf("v%0d rd_enable", idx), {31'b0, rd_en_out}, {31'b0, e.ee});
        chk($sformatf("v%0d misalign", idx), {31'b0, misalign}, {31'b0, e.em});
        chk($sformatf("v%0d write_count", idx), wr_log.size() - base, e.nwr);
        for (int i = 0; i < e.nwr && base + i < wr_log.size(); i++) begin
            w = wr_log[base + i];
            t = e.d >> (8 * i);
            chk($sformatf("v%0d wr%0d addr", idx, i), w[39:8], e.addr + i);
            chk($sformatf("v%0d wr%0d data", idx, i), {24'b0, w[7:0]}, {24'b0, t[7:0]});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1;
        drive(mk(`ADD, 32'h12345678, 5'd5, 1'b1, 32'h0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        chk("rst stall_req", {31'b0, stall_req}, 32'h0);
        chk("rst rd_data", rd_data_out, 32'h0);
        chk("rst rd_addr", {27'b0, rd_addr_out}, 32'h0);
        chk("rst rd_enable", {31'b0, rd_en_out}, 32'h0);
        chk("rst mem_wr", {31'b0, mif.mem_wr}, 32'h0);
        chk("rst misalign", {31'b0, misalign}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post-rst mem_a", mif.mem_a, 32'h0);
        chk("post-rst passthrough", rd_data_out, 32'h12345678);
        @(posedge clk);
        #1;

        tbl.push_back(mk(`ADD, 32'h12345678, 5'd5, 1'b1, 32'h0,   32'h12345678, 5'd5, 1'b1, 1'b0, 1, 0));
        tbl.push_back(mk(`SW,  32'hA1B2C3D4, 5'd7, 1'b1, 32'h100, 32'h0,        5'd7, 1'b0, 1'b0, 6, 4));
        tbl.push_back(mk(`LW,  32'h0,        5'd3, 1'b1, 32'h100, 32'hA1B2C3D4, 5'd3, 1'b1, 1'b0, 7, 0));
        tbl.push_back(mk(`LB,  32'h0,        5'd4, 1'b1, 32'h103, 32'hFFFFFFA1, 5'd4, 1'b1, 1'b0, 4, 0));
        tbl.push_back(mk(`LBU, 32'h0,        5'd4, 1'b1, 32'h103, 32'h000000A1, 5'd4, 1'b1, 1'b0, 4, 0));
        tbl.push_back(mk(`LH,  32'h0,        5'd6, 1'b1, 32'h102, 32'hFFFFA1B2, 5'd6, 1'b1, 1'b0, 5, 0));
        tbl.push_back(mk(`LHU, 32'h0,        5'd6, 1'b1, 32'h100, 32'h0000C3D4, 5'd6, 1'b1, 1'b0, 5, 0));
        tbl.push_back(mk(`SB,  32'h00000080, 5'd0, 1'b0, 32'h104, 32'h0,        5'd0, 1'b0, 1'b0, 3, 1));
        tbl.push_back(mk(`LB,  32'h0,        5'd8, 1'b1, 32'h104, 32'hFFFFFF80, 5'd8, 1'b1, 1'b0, 4, 0));
        tbl.push_back(mk(`SH,  32'h00007F01, 5'd0, 1'b0, 32'h106, 32'h0,        5'd0, 1'b0, 1'b0, 4, 2));
        tbl.push_back(mk(`LW,  32'h0,        5'd9, 1'b1, 32'h104, 32'h7F010080, 5'd9, 1'b1, 1'b0, 7, 0));
        tbl.push_back(mk(`NOP, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0,   32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1, 0));
        tbl.push_back(mk(`ADD, 32'h00000055, 5'd0, 1'b1, 32'h0,   32'h00000055, 5'd0, 1'b1, 1'b0, 1, 0));
`ifndef MEM_MISALIGN_CHECK_EN
        tbl.push_back(mk(`SW,  32'h44332211, 5'd0, 1'b0, 32'hFFFFFFFE, 32'h0,        5'd0, 1'b0, 1'b0, 6, 4));
        tbl.push_back(mk(`LW,  32'h0,        5'd1, 1'b1, 32'hFFFFFFFF, 32'h00443322, 5'd1, 1'b1, 1'b0, 7, 0));
        tbl.push_back(mk(`SH,  32'h0000BEEF, 5'd0, 1'b0, 32'h301,      32'h0,        5'd0, 1'b0, 1'b0, 4, 2));
        tbl.push_back(mk(`LH,  32'h0,        5'd2, 1'b1, 32'h301,      32'hFFFFBEEF, 5'd2, 1'b1, 1'b0, 5, 0));
`else
        tbl.push_back(mk(`SW,  32'h99887766, 5'd2, 1'b1, 32'h102, 32'h0, 5'd0, 1'b0, 1'b1, 1, 0));
        tbl.push_back(mk(`LH,  32'h0,        5'd2, 1'b1, 32'h101, 32'h0, 5'd0, 1'b0, 1'b1, 1, 0));
        tbl.push_back(mk(`LW,  32'h0,        5'd3, 1'b1, 32'h100, 32'hA1B2C3D4, 5'd3, 1'b1, 1'b0, 7, 0));
`endif
        foreach (tbl[i]) run_vec(tbl[i], i);
        chk("scoreboard drained", sb.size(), 32'h0);

        // Reset lands while the third store byte is on the bus: only two bytes may reach RAM.
        drive(mk(`SW, 32'h11223344, 5'd1, 1'b0, 32'h200, 0, 0, 0, 0, 0, 0));
        base = wr_log.size();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst stall_req", {31'b0, stall_req}, 32'h0);
        chk("midrst mem_wr", {31'b0, mif.mem_wr}, 32'h0);
        chk("midrst rd_enable", {31'b0, rd_en_out}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(mk(`NOP, 32'h0, 5'd0, 1'b0, 32'h0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("after-rst stall_req", {31'b0, stall_req}, 32'h0);
        chk("after-rst mem_wr", {31'b0, mif.mem_wr}, 32'h0);
        chk("after-rst mem_a", mif.mem_a, 32'h0);
        chk("midrst write_count", wr_log.size() - base, 32'd2);
        chk("ram 0x200", {24'b0, ram[10'h200]}, 32'h44);
        chk("ram 0x201", {24'b0, ram[10'h201]}, 32'h33);
        chk("ram 0x202", {24'b0, ram[10'h202]}, 32'h00);
        @(posedge clk);
        #1;
        run_vec(mk(`LW, 32'h0, 5'd10, 1'b1, 32'h200, 32'h00003344, 5'd10, 1'b1, 1'b0, 7, 0), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
